data_mem_bus: RTL and testbench

Memory-mapped bus responder on the CPU data port: answers the core's `read`/`write`/`address`/`dout` requests and returns `din`. It contains a word-addressed data RAM, an LED output register, a free-running cycle counter and a console transmit FIFO drained by an external sink. It sits between the CPU and the board I/O, as the target end of the CPU's single-cycle load/store interface.

---
 rtl/bus_map_pkg.sv | 34 +++
 rtl/tx_fifo.sv | 61 ++++++
 rtl/data_mem_bus.sv | 139 +++++++++++++
 tb/tb_data_mem_bus.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_map_pkg.sv
// bus_map_pkg: address map shared by the data-port bus responder.
// Region codes live in address[31:28]; MMIO registers are picked by address[1:0].
package bus_map_pkg;

    localparam logic [3:0] REGION_RAM  = 4'h0;
    localparam logic [3:0] REGION_MMIO = 4'h8;

    typedef enum logic [1:0] {
        MMIO_LED    = 2'd0,
        MMIO_CYCLE  = 2'd1,
        MMIO_TXDATA = 2'd2,
        MMIO_STATUS = 2'd3
    } mmio_sel_e;

    localparam int STATUS_OVF_BIT   = 31;
    localparam int STATUS_FULL_BIT  = 9;
    localparam int STATUS_EMPTY_BIT = 8;
    localparam int STATUS_COUNT_MSB = 7;
    localparam int STATUS_COUNT_LSB = 0;

    function automatic logic [31:0] pack_status(input logic       ovf,
                                                input logic       full,
                                                input logic       empty,
                                                input logic [7:0] count);
        logic [31:0] s;
        s                                   = '0;
        s[STATUS_OVF_BIT]                   = ovf;
        s[STATUS_FULL_BIT]                  = full;
        s[STATUS_EMPTY_BIT]                 = empty;
        s[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = count;
        return s;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: small byte FIFO feeding the console sink.
// A push while full is accepted only when a pop frees a slot in the same cycle;
// the caller decides what a rejected push means. Storage is reset so the head
// byte reads 0 after reset.
module tx_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [7:0]                    push_data,
    input  logic                          pop,
    output logic [7:0]                    head,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    store [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_pop;
    logic          do_push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(FIFO_DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = store[rd_ptr];
    assign count   = cnt;

    // Pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (do_push) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_bus.sv
// data_mem_bus: target end of the CPU single-cycle load/store port.
// Holds the data RAM, LED register, free-running cycle counter and, when
// DMEM_CONSOLE_EN is defined, the console transmit FIFO with its TXDATA and
// STATUS registers. Without DMEM_CONSOLE_EN those two offsets read 0 and
// ignore writes, and the tx_* outputs are tied low.
module data_mem_bus
    import bus_map_pkg::*;
#(
    parameter int RAM_AW     = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int LED_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write,
    input  logic             read,
    input  logic [31:0]      address,
    input  logic [31:0]      dout,
    output logic [31:0]      din,
    output logic [LED_W-1:0] led,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    logic [31:0]       ram [2**RAM_AW];
    logic [31:0]       cycle_cnt;
    logic [3:0]        region;
    mmio_sel_e         sel;
    logic              ram_hit;
    logic              mmio_hit;
    logic              rd_en;
    logic [31:0]       status_word;
    logic              unused_in;

    assign region   = address[31:28];
    assign sel      = mmio_sel_e'(address[1:0]);
    assign ram_hit  = (region == REGION_RAM);
    assign mmio_hit = (region == REGION_MMIO);
    // A simultaneous read and write is serviced as a write, so no read data.
    assign rd_en    = read & ~write;

    // Upper address bits alias onto the decoded ranges.
    assign unused_in = ^{address, tx_ready};

`ifdef DMEM_CONSOLE_EN
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       fifo_head;
    logic             overflow;

    assign fifo_push = write & mmio_hit & (sel == MMIO_TXDATA);
    assign fifo_pop  = ~fifo_empty & tx_ready;

    tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (dout[7:0]),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign tx_valid    = ~fifo_empty;
    assign tx_data     = fifo_head;
    assign status_word = pack_status(overflow, fifo_full, fifo_empty, 8'(fifo_count));

    // Sticky overflow: set by a dropped push, cleared by any STATUS write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (write && mmio_hit && sel == MMIO_STATUS) begin
            overflow <= 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end
`else
    assign tx_valid    = 1'b0;
    assign tx_data     = '0;
    assign status_word = '0;
`endif

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (write && ram_hit) begin
            ram[address[RAM_AW-1:0]] <= dout;
        end
    end

    // LED register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led <= '0;
        end else if (write && mmio_hit && sel == MMIO_LED) begin
            led <= dout[LED_W-1:0];
        end
    end

    // Free-running cycle counter; a CPU load wins over the increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
        end else if (write && mmio_hit && sel == MMIO_CYCLE) begin
            cycle_cnt <= dout;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Combinational read mux; zero whenever no plain read is in progress.
    always_comb begin
        din = '0;
        if (rd_en) begin
            if (ram_hit) begin
                din = ram[address[RAM_AW-1:0]];
            end else if (mmio_hit) begin
                case (sel)
                    MMIO_LED:    din = 32'(led);
                    MMIO_CYCLE:  din = cycle_cnt;
                    MMIO_TXDATA: din = '0;
                    MMIO_STATUS: din = status_word;
                    default:     din = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_mem_bus.sv
// Bench for data_mem_bus: directed scenarios followed by random traffic.
// Expected read data and console bytes are queued as stimulus is issued and
// consumed by a monitor whenever the DUT presents a read or a byte transfer.
module tb_data_mem_bus;

    localparam int RAM_AW     = 10;
    localparam int FIFO_DEPTH = 8;
    localparam int LED_W      = 16;

    localparam logic [31:0] A_LED    = 32'h8000_0000;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0001;
    localparam logic [31:0] A_TXDATA = 32'h8000_0002;
    localparam logic [31:0] A_STATUS = 32'h8000_0003;

    logic             clk = 1'b0;
    logic             rst;
    logic             write;
    logic             read;
    logic [31:0]      address;
    logic [31:0]      dout;
    logic [31:0]      din;
    logic [LED_W-1:0] led;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [31:0] m_ram [int];
    int          written_idx[$];
    logic [15:0] m_led;
    logic [31:0] m_cycle;
    logic [7:0]  m_q[$];
    bit          m_ovf;

    // scoreboards
    logic [31:0] sb_din[$];
    logic [7:0]  sb_tx[$];

    data_mem_bus #(
        .RAM_AW     (RAM_AW),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LED_W      (LED_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .write    (write),
        .read     (read),
        .address  (address),
        .dout     (dout),
        .din      (din),
        .led      (led),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int idx;
        if (a[31:28] == 4'h0) begin
            idx = int'(a[RAM_AW-1:0]);
            return m_ram[idx];
        end else if (a[31:28] == 4'h8) begin
            case (a[1:0])
                2'd0: return {16'h0, m_led};
                2'd1: return m_cycle;
                2'd2: return 32'h0;
`ifdef DMEM_CONSOLE_EN
                2'd3: return {m_ovf, 21'h0, m_q.size() == FIFO_DEPTH, m_q.size() == 0,
                              8'(m_q.size())};
`endif
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    task automatic model_commit(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic rdy);
        bit is_mmio;
        is_mmio = (a[31:28] == 4'h8);
        if (w && a[31:28] == 4'h0) begin
            m_ram[int'(a[RAM_AW-1:0])] = d;
            written_idx.push_back(int'(a[RAM_AW-1:0]));
        end
        if (w && is_mmio && a[1:0] == 2'd0) m_led = d[15:0];
        if (w && is_mmio && a[1:0] == 2'd1) m_cycle = d;
        else                                 m_cycle = m_cycle + 32'd1;
`ifdef DMEM_CONSOLE_EN
        begin
            bit pop, push, was_full;
            pop      = (m_q.size() > 0) && rdy;
            push     = w && is_mmio && a[1:0] == 2'd2;
            was_full = (m_q.size() == FIFO_DEPTH);
            if (w && is_mmio && a[1:0] == 2'd3) m_ovf = 1'b0;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (was_full && !pop) begin
                    m_ovf = 1'b1;
                end else begin
                    m_q.push_back(d[7:0]);
                    sb_tx.push_back(d[7:0]);
                end
            end
        end
`endif
    endtask

    // One bus cycle: drive, queue the expected read data, then let the edge commit.
    task automatic cyc(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
        write    = w;
        read     = r;
        address  = a;
        dout     = d;
        tx_ready = rdy;
        if (r && !w) sb_din.push_back(model_read(a));
        @(posedge clk);
        model_commit(w, a, d, rdy);
        #1;
    endtask

    task automatic set_idle();
        write    = 1'b0;
        read     = 1'b0;
        address  = '0;
        dout     = '0;
        tx_ready = 1'b0;
    endtask

    task automatic model_reset();
        m_led   = '0;
        m_cycle = '0;
        m_ovf   = 1'b0;
        m_q.delete();
        sb_tx.delete();
    endtask

    // Assert reset between edges and observe the cleared outputs before any clock.
    task automatic mid_reset();
        #1 rst = 1'b0;
        model_reset();
        set_idle();
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        read    = 1'b1;
        address = A_STATUS;
        #1;
`ifdef DMEM_CONSOLE_EN
        check("rst_status", din, 32'h0000_0100);
`else
        check("rst_status", din, 32'h0);
`endif
        address = A_CYCLE;
        #1;
        check("rst_cycle", din, 32'h0);
        set_idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Monitor: consumes scoreboard entries whenever the DUT presents an output.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (read && !write) begin
                if (sb_din.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL din_unexpected: got %h expected nothing queued", din);
                end else begin
                    check("din", din, sb_din.pop_front());
                end
            end else begin
                check("din_idle", din, 32'h0);
            end
            check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
            check("led", 32'(led), 32'(m_led));
            if (tx_valid && tx_ready) begin
                if (sb_tx.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tx_unexpected: got %h expected nothing queued", tx_data);
                end else begin
                    check("tx_data", 32'(tx_data), 32'(sb_tx.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  rg;
        int          k;
        logic        rdy;

        set_idle();
        model_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("reset_tx_valid", 32'(tx_valid), 32'h0);
        check("reset_led", 32'(led), 32'h0);
        check("reset_tx_data", 32'(tx_data), 32'h0);
        check("reset_din", din, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // counter counts idle cycles from reset release
        repeat (10) cyc(0, 0, 32'h0, 32'h0, 0);
        cyc(0, 1, A_CYCLE, 32'h0, 0);

        // RAM write, read back, aliased read
        cyc(1, 0, 32'd5, 32'hDEAD_BEEF, 0);
        cyc(0, 1, 32'd5, 32'h0, 0);
        cyc(0, 1, 32'd5 + 32'(2 ** RAM_AW), 32'h0, 0);

        // LED and unmapped
        cyc(1, 0, A_LED, 32'h1234_ABCD, 0);
        check("led_abcd", 32'(led), 32'h0000_ABCD);
        cyc(0, 1, A_LED, 32'h0, 0);
        cyc(0, 1, 32'h4000_0000, 32'h0, 0);

        // counter wrap
        cyc(1, 0, A_CYCLE, 32'hFFFF_FFFE, 0);
        cyc(0, 0, 32'h0, 32'h0, 0);
        cyc(0, 0, 32'h0, 32'h0, 0);
        cyc(0, 1, A_CYCLE, 32'h0, 0);

`ifdef DMEM_CONSOLE_EN
        for (int i = 0; i < FIFO_DEPTH; i++) cyc(1, 0, A_TXDATA, 32'h41 + 32'(i), 0);
        cyc(0, 1, A_STATUS, 32'h0, 0);
        cyc(1, 0, A_TXDATA, 32'h49, 0);
        cyc(0, 1, A_STATUS, 32'h0, 0);
        cyc(1, 0, A_STATUS, 32'h0, 0);
        cyc(0, 1, A_STATUS, 32'h0, 0);
        repeat (FIFO_DEPTH) cyc(0, 0, 32'h0, 32'h0, 1);
        check("drained_tx_valid", 32'(tx_valid), 32'h0);
        cyc(0, 1, A_STATUS, 32'h0, 0);
        for (int i = 0; i < FIFO_DEPTH; i++) cyc(1, 0, A_TXDATA, 32'h41 + 32'(i), 0);
        cyc(1, 0, A_TXDATA, 32'h50, 1);
        cyc(0, 1, A_STATUS, 32'h0, 0);
        repeat (FIFO_DEPTH - 3) cyc(0, 0, 32'h0, 32'h0, 1);
`else
        cyc(1, 0, A_TXDATA, 32'h41, 1);
        cyc(0, 1, A_TXDATA, 32'h0, 1);
        cyc(0, 1, A_STATUS, 32'h0, 1);
        cyc(1, 0, A_STATUS, 32'hFFFF_FFFF, 1);
        cyc(0, 1, A_STATUS, 32'h0, 0);
`endif
        cyc(1, 0, A_LED, 32'h0000_00FF, 0);
        check("led_ff", 32'(led), 32'h0000_00FF);
        mid_reset();
        cyc(0, 1, A_LED, 32'h0, 0);
        cyc(0, 1, A_CYCLE, 32'h0, 0);
        cyc(0, 1, 32'd5, 32'h0, 0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            k   = $urandom_range(0, 9);
            rdy = 1'($urandom_range(0, 1));
            d   = $urandom;
            case (k)
                0: cyc(1, 0, {4'h0, 18'($urandom), 10'($urandom)}, d, rdy);
                1: begin
                    if (written_idx.size() > 0) begin
                        a = {4'h0, 18'($urandom),
                             10'(written_idx[$urandom_range(0, written_idx.size() - 1)])};
                        cyc(0, 1, a, 32'h0, rdy);
                    end else begin
                        cyc(0, 0, 32'h0, 32'h0, rdy);
                    end
                end
                2: cyc(1'($urandom_range(0, 1)), 1'b1, {4'h8, 26'($urandom), 2'd0}, d, rdy);
                3: cyc(($urandom_range(0, 7) == 0), 1'b1, {4'h8, 26'($urandom), 2'd1}, d, rdy);
                4: cyc(1, 0, {4'h8, 26'($urandom), 2'd2}, d, rdy);
                5: cyc(0, 1, {4'h8, 26'($urandom), 2'd3}, 32'h0, rdy);
                6: cyc(($urandom_range(0, 3) == 0), 1'b1, {4'h8, 26'($urandom), 2'd3}, d, rdy);
                7: begin
                    rg = 4'($urandom_range(1, 15));
                    if (rg == 4'h8) rg = 4'h9;
                    cyc(1'($urandom_range(0, 1)), 1'b1, {rg, 28'($urandom)}, d, rdy);
                end
                8: begin
                    a = ($urandom_range(0, 1) == 1) ? {4'h0, 18'h0, 10'($urandom)}
                                                    : {4'h8, 26'h0, 2'($urandom)};
                    cyc(1, 1, a, d, rdy);
                end
                default: cyc(0, 0, 32'h0, 32'h0, rdy);
            endcase
        end

        repeat (FIFO_DEPTH + 2) cyc(0, 0, 32'h0, 32'h0, 1);
        set_idle();
        #1;
        check("final_tx_valid", 32'(tx_valid), 32'h0);
        check("din_queue_left", 32'(sb_din.size()), 32'h0);
        check("tx_queue_left", 32'(sb_tx.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
